// File: rtl/m_wbuart_pkg.sv
// Shared definitions for the Wishbone UART: register offsets, STATUS bit
// positions, FSM state types and a STATUS packing helper. Board tops that
// talk to the UART import this package for the same offsets and bit numbers.
package m_wbuart_pkg;

  // Register select (core ADR_O[2])
  localparam logic ADR_DATA   = 1'b0;
  localparam logic ADR_STATUS = 1'b1;

  // STATUS bit positions; the clear bits of a STATUS write share them
  localparam int ST_RXVALID = 0;
  localparam int ST_TXFULL  = 1;
  localparam int ST_TXIDLE  = 2;
  localparam int ST_OVERRUN = 3;
  localparam int ST_FRAMING = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  function automatic logic [7:0] pack_status(input logic framing, input logic overrun,
                                             input logic txidle, input logic txfull,
                                             input logic rxvalid);
    logic [7:0] s;
    s             = 8'h00;
    s[ST_FRAMING] = framing;
    s[ST_OVERRUN] = overrun;
    s[ST_TXIDLE]  = txidle;
    s[ST_TXFULL]  = txfull;
    s[ST_RXVALID] = rxvalid;
    return s;
  endfunction

endpackage

// File: rtl/m_wbuart_if.sv
// Wishbone slave bus bundle for m_wbuart.
//   STB_I  strobe (already address-decoded)   WE_I  write enable
//   ADR_I  0=DATA, 1=STATUS                    DAT_I write data
//   ACK_O  acknowledge                         DAT_O read data (0 when ACK_O=0)
interface m_wbuart_if;
  logic       STB_I;
  logic       WE_I;
  logic       ADR_I;
  logic [7:0] DAT_I;
  logic       ACK_O;
  logic [7:0] DAT_O;

  modport slave (
    input  STB_I, WE_I, ADR_I, DAT_I,
    output ACK_O, DAT_O
  );

  modport master (
    output STB_I, WE_I, ADR_I, DAT_I,
    input  ACK_O, DAT_O
  );
endinterface

// File: rtl/m_uart_rx.sv
// 8N1 UART receiver.
//   clk, rst   system clock, synchronous active-high reset
//   rx         asynchronous serial input
//   rx_byte    last assembled byte (valid when done pulses)
//   done       1-cycle pulse: a frame with a good stop bit completed
//   frame_err  1-cycle pulse: the stop bit was sampled as 0
module m_uart_rx
  import m_wbuart_pkg::*;
#(
  parameter int CLKDIV = 286
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       frame_err
);

  localparam logic [15:0] DIV_M1  = 16'(CLKDIV - 1);
  localparam logic [15:0] HALF_M1 = 16'((CLKDIV / 2) - 1);

  logic [1:0] sync;
  logic       s;
  logic       s_d;
  rx_state_t  state;
  logic [15:0] cnt;
  logic [2:0]  bitn;
  logic        sample_data;

  assign s           = sync[1];
  assign sample_data = (state == RX_DATA) && (cnt == 16'd0);

  // Synchroniser and prior-value flop reset to the idle level so a reset
  // never manufactures a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= 2'b11;
      s_d       <= 1'b1;
      state     <= RX_IDLE;
      cnt       <= 16'd0;
      bitn      <= 3'd0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      s_d       <= s;
      done      <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (s_d && !s) begin
            state <= RX_START;
            cnt   <= HALF_M1;
          end
        end
        RX_START: begin
          if (cnt == 16'd0) begin
            if (s) begin
              state <= RX_IDLE;          // glitch, not a start bit
            end else begin
              state <= RX_DATA;
              cnt   <= DIV_M1;
              bitn  <= 3'd0;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RX_DATA: begin
          if (cnt == 16'd0) begin
            cnt <= DIV_M1;
            if (bitn == 3'd7) state <= RX_STOP;
            else              bitn  <= bitn + 3'd1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RX_STOP: begin
          if (cnt == 16'd0) begin
            if (s) begin
              done  <= 1'b1;
              state <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= RX_WAIT;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        RX_WAIT: begin
          if (s) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Data bits arrive LSB first
  always_ff @(posedge clk) begin
    if (sample_data) rx_byte <= {s, rx_byte[7:1]};
  end

endmodule

// File: rtl/m_wbuart.sv
// Wishbone-slave 8N1 UART.
//   CLK_I, RST_I  system clock, synchronous active-high reset
//   wb            Wishbone slave (STB_I, WE_I, ADR_I, DAT_I, ACK_O, DAT_O)
//   uart_tx       serial out, idle high
//   uart_rx       serial in, asynchronous
// DATA write pushes into the TX FIFO (dropped when full), DATA read returns
// the RX holding register and clears rxvalid. STATUS read returns
// {3'b0, framing, overrun, txidle, txfull, rxvalid}; STATUS write bits 3/4
// clear overrun/framing.
module m_wbuart
  import m_wbuart_pkg::*;
#(
  parameter int CLKDIV      = 286,
  parameter int TXDEPTHLOG2 = 2
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  m_wbuart_if.slave  wb,
  output logic       uart_tx,
  input  logic       uart_rx
);

  localparam int DEPTH = 1 << TXDEPTHLOG2;
  localparam int CW    = TXDEPTHLOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [15:0]   DIV_M1   = 16'(CLKDIV - 1);

  logic       ack_p1;
  logic [7:0] rdat_p1;
  logic       take, rd_data, wr_status, push, pop, txfull, txidle;
  logic [7:0] status;

  logic       rxvalid, overrun, framing;
  logic [7:0] rx_hold;
  logic [7:0] rx_byte;
  logic       rx_done, rx_ferr;
  logic       set_overrun;

  logic [7:0]             mem [DEPTH];
  logic [TXDEPTHLOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]          count;

  tx_state_t   tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_shift;

  m_uart_rx #(.CLKDIV(CLKDIV)) u_rx (
    .clk       (CLK_I),
    .rst       (RST_I),
    .rx        (uart_rx),
    .rx_byte   (rx_byte),
    .done      (rx_done),
    .frame_err (rx_ferr)
  );

  // Access decode: a strobe is taken only while no acknowledge is pending
  assign take      = wb.STB_I & ~ack_p1;
  assign rd_data   = take & ~wb.WE_I & (wb.ADR_I == ADR_DATA);
  assign wr_status = take &  wb.WE_I & (wb.ADR_I == ADR_STATUS);
  assign push      = take &  wb.WE_I & (wb.ADR_I == ADR_DATA) & ~txfull;

  assign txfull = (count == FULL_CNT);
  assign txidle = (count == '0) && (tx_state == TX_IDLE);
  // Pop from IDLE, or straight out of a finishing stop bit for back-to-back frames
  assign pop = (count != '0) &&
               ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_cnt == 16'd0)));

  // A read racing a completing byte clears the old byte, so no overrun
  assign set_overrun = rx_done & rxvalid & ~rd_data;

  assign status = pack_status(framing, overrun, txidle, txfull, rxvalid);

  // Response stage p1
  always_ff @(posedge CLK_I) begin
    if (RST_I) ack_p1 <= 1'b0;
    else       ack_p1 <= take;
  end

  always_ff @(posedge CLK_I) begin
    if (take) rdat_p1 <= (wb.ADR_I == ADR_STATUS) ? status : rx_hold;
  end

  assign wb.ACK_O = ack_p1;
  assign wb.DAT_O = ack_p1 ? rdat_p1 : 8'h00;

  // RX flags: a new event wins over a clear in the same cycle
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      rxvalid <= 1'b0;
      overrun <= 1'b0;
      framing <= 1'b0;
    end else begin
      rxvalid <= rx_done | (rxvalid & ~rd_data);
      overrun <= set_overrun | (overrun & ~(wr_status & wb.DAT_I[ST_OVERRUN]));
      framing <= rx_ferr     | (framing & ~(wr_status & wb.DAT_I[ST_FRAMING]));
    end
  end

  always_ff @(posedge CLK_I) begin
    if (rx_done) rx_hold <= rx_byte;
  end

  // TX FIFO control
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    if (push) mem[wr_ptr] <= wb.DAT_I;
  end

  // TX shifter: each state/bit lasts CLKDIV cycles on a down-counter
  assign tx_shift = (tx_state == TX_DATA) && (tx_cnt == 16'd0) && (tx_bit != 3'd7);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            tx_state <= TX_START;
            tx_cnt   <= DIV_M1;
            uart_tx  <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt == 16'd0) begin
            tx_state <= TX_DATA;
            tx_cnt   <= DIV_M1;
            tx_bit   <= 3'd0;
            uart_tx  <= tx_sh[0];
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == 16'd0) begin
            tx_cnt <= DIV_M1;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              uart_tx  <= 1'b1;
            end else begin
              tx_bit  <= tx_bit + 3'd1;
              uart_tx <= tx_sh[1];
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == 16'd0) begin
            if (pop) begin
              tx_state <= TX_START;
              tx_cnt   <= DIV_M1;
              uart_tx  <= 1'b0;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 16'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    if (pop)           tx_sh <= mem[rd_ptr];
    else if (tx_shift) tx_sh <= {1'b0, tx_sh[7:1]};
  end

endmodule

// File: tb/tb_m_wbuart.sv
// Self-checking bench for m_wbuart (CLKDIV=8, 4-entry TX FIFO).
// A frame-level model (byte queue, frame start time, flag bits) predicts
// ACK_O, DAT_O and uart_tx every cycle; directed cases pin the model with
// hand-computed literals, then a randomized phase mixes bus and RX traffic.
module tb_m_wbuart;

  localparam int CLKDIV = 8;
  localparam int TXL    = 2;
  localparam int DEPTH  = 4;
  localparam int FRAME  = 10 * CLKDIV;

  logic CLK_I = 1'b0;
  logic RST_I;
  logic uart_tx;
  logic uart_rx;

  m_wbuart_if wb();

  m_wbuart #(.CLKDIV(CLKDIV), .TXDEPTHLOG2(TXL)) dut (
    .CLK_I   (CLK_I),
    .RST_I   (RST_I),
    .wb      (wb),
    .uart_tx (uart_tx),
    .uart_rx (uart_rx)
  );

  always #5 CLK_I = ~CLK_I;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [7:0] m_q[$];
  bit         m_active;
  int         m_elapsed;
  logic [7:0] m_cur;
  bit         m_ack;
  bit         m_ack_rd;
  logic [7:0] m_rdat;
  bit         m_rxvalid, m_overrun, m_framing;
  logic [7:0] m_hold;
  bit         prev_ack;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    logic [7:0] s;
    s = {3'b000, m_framing, m_overrun, (m_q.size() == 0 && !m_active),
         (m_q.size() >= DEPTH), m_rxvalid};
    return s;
  endfunction

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  // Advance the model by one clock edge, using the inputs the DUT sees
  task automatic model_step();
    bit take, full;
    if (RST_I) begin
      m_q.delete();
      m_active  = 0;
      m_elapsed = 0;
      m_ack     = 0;
      m_ack_rd  = 0;
      m_rxvalid = 0;
      m_overrun = 0;
      m_framing = 0;
      return;
    end
    take = wb.STB_I && !m_ack;
    full = (m_q.size() >= DEPTH);
    if (take && !wb.WE_I) m_rdat = wb.ADR_I ? m_status() : m_hold;
    if (take && !wb.WE_I && !wb.ADR_I) m_rxvalid = 0;
    if (take && wb.WE_I && wb.ADR_I) begin
      if (wb.DAT_I[3]) m_overrun = 0;
      if (wb.DAT_I[4]) m_framing = 0;
    end
    if (m_active) begin
      m_elapsed++;
      if (m_elapsed == FRAME) m_active = 0;
    end
    if (!m_active && m_q.size() != 0) begin
      m_cur     = m_q.pop_front();
      m_active  = 1;
      m_elapsed = 0;
    end
    if (take && wb.WE_I && !wb.ADR_I && !full) m_q.push_back(wb.DAT_I);
    m_ack_rd = take && !wb.WE_I;
    m_ack    = take;
  endtask

  task automatic compare();
    logic exp_tx;
    check("ack", 16'(wb.ACK_O), 16'(m_ack));
    if (!m_ack)        check("dat_idle", 16'(wb.DAT_O), 16'h0000);
    else if (m_ack_rd) check("dat_read", 16'(wb.DAT_O), 16'(m_rdat));
    exp_tx = m_active ? frame_bit(m_cur, m_elapsed / CLKDIV) : 1'b1;
    check("uart_tx", 16'(uart_tx), 16'(exp_tx));
    if (prev_ack) check("ack_twice", 16'(wb.ACK_O), 16'h0000);
    prev_ack = wb.ACK_O;
  endtask

  task automatic tick();
    @(posedge CLK_I);
    model_step();
    @(negedge CLK_I);
    compare();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic bus(input bit we, input bit adr, input logic [7:0] d, output logic [7:0] rd);
    wb.STB_I = 1'b1;
    wb.WE_I  = we;
    wb.ADR_I = adr;
    wb.DAT_I = d;
    tick();
    rd = wb.DAT_O;
    wb.STB_I = 1'b0;
    wb.WE_I  = 1'b0;
    tick();
  endtask

  // Drive one 8N1 frame, then let the model record its outcome
  task automatic rx_frame(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    idle(CLKDIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(CLKDIV);
    end
    uart_rx = stop_ok;
    idle(CLKDIV);
    uart_rx = 1'b1;
    idle(CLKDIV);
    if (stop_ok) begin
      if (m_rxvalid) m_overrun = 1;
      m_hold    = b;
      m_rxvalid = 1;
    end else begin
      m_framing = 1;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((m_active || m_q.size() != 0) && n < 2000) begin
      tick();
      n++;
    end
    check(name, 16'(n < 2000), 16'h0001);
    idle(2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic [8:0] pat;
    int w, lows;

    RST_I    = 1'b1;
    uart_rx  = 1'b1;
    wb.STB_I = 1'b0;
    wb.WE_I  = 1'b0;
    wb.ADR_I = 1'b0;
    wb.DAT_I = 8'h00;
    prev_ack = 0;
    m_hold   = 8'h00;
    m_rdat   = 8'h00;
    m_cur    = 8'h00;
    idle(2);
    check("reset_tx", 16'(uart_tx), 16'h0001);
    check("reset_ack", 16'(wb.ACK_O), 16'h0000);
    RST_I = 1'b0;
    idle(2);
    bus(0, 1, 8'h00, rd);
    check("reset_status", 16'(rd), 16'h0004);

    // 1: single byte 0x55
    bus(1, 0, 8'h55, rd);
    w = 0;
    while (uart_tx !== 1'b0 && w < 10) begin tick(); w++; end
    check("t1_start_seen", 16'(uart_tx), 16'h0000);
    lows = 0;
    while (uart_tx === 1'b0 && lows < 20) begin lows++; tick(); end
    check("t1_start_len", 16'(lows), 16'd8);
    idle(3);
    pat = {1'b1, 8'h55};
    for (int i = 0; i < 9; i++) begin
      check("t1_bit", 16'(uart_tx), 16'(pat[i]));
      idle(CLKDIV);
    end
    drain("t1_drain");
    bus(0, 1, 8'h00, rd);
    check("t1_status", 16'(rd), 16'h0004);

    // 2: five bytes then one dropped while full
    for (int b = 1; b <= 5; b++) bus(1, 0, 8'(b), rd);
    bus(0, 1, 8'h00, rd);
    check("t2_full_status", 16'(rd), 16'h0002);
    bus(1, 0, 8'h06, rd);
    drain("t2_drain");
    bus(0, 1, 8'h00, rd);
    check("t2_status", 16'(rd), 16'h0004);

    // 3: receive 0xA3
    rx_frame(8'hA3, 1);
    bus(0, 1, 8'h00, rd);
    check("t3_status_valid", 16'(rd), 16'h0005);
    bus(0, 0, 8'h00, rd);
    check("t3_data", 16'(rd), 16'h00A3);
    bus(0, 1, 8'h00, rd);
    check("t3_status_after", 16'(rd), 16'h0004);

    // 4: overrun
    rx_frame(8'h11, 1);
    rx_frame(8'h22, 1);
    bus(0, 1, 8'h00, rd);
    check("t4_status_ovr", 16'(rd), 16'h000D);
    bus(0, 0, 8'h00, rd);
    check("t4_data", 16'(rd), 16'h0022);
    bus(1, 1, 8'h08, rd);
    bus(0, 1, 8'h00, rd);
    check("t4_status_clr", 16'(rd), 16'h0004);

    // 5: glitch, then framing error with rxvalid held
    rx_frame(8'h77, 1);
    uart_rx = 1'b0;
    idle(3);
    uart_rx = 1'b1;
    idle(20);
    bus(0, 1, 8'h00, rd);
    check("t5_glitch_status", 16'(rd), 16'h0005);
    rx_frame(8'h3C, 0);
    bus(0, 1, 8'h00, rd);
    check("t5_framing_status", 16'(rd), 16'h0015);
    bus(0, 0, 8'h00, rd);
    check("t5_data_kept", 16'(rd), 16'h0077);
    bus(1, 1, 8'h10, rd);
    bus(0, 1, 8'h00, rd);
    check("t5_status_clr", 16'(rd), 16'h0004);

    // 6: constant strobe, then reset mid TX and mid RX frame
    wb.STB_I = 1'b1;
    wb.WE_I  = 1'b0;
    wb.ADR_I = 1'b1;
    idle(10);
    wb.STB_I = 1'b0;
    idle(1);
    bus(1, 0, 8'h5A, rd);
    uart_rx = 1'b0;
    idle(30);
    uart_rx  = 1'b1;
    wb.STB_I = 1'b1;
    RST_I    = 1'b1;
    tick();
    RST_I    = 1'b0;
    wb.STB_I = 1'b0;
    check("t6_tx_after_rst", 16'(uart_tx), 16'h0001);
    check("t6_ack_after_rst", 16'(wb.ACK_O), 16'h0000);
    idle(1);
    bus(0, 1, 8'h00, rd);
    check("t6_status", 16'(rd), 16'h0004);
    idle(20);
    bus(0, 1, 8'h00, rd);
    check("t6_status_late", 16'(rd), 16'h0004);

    // Randomized mix
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 5))
        0: bus(1, 0, 8'($urandom_range(0, 255)), rd);
        1: bus(0, 1, 8'h00, rd);
        2: bus(0, !m_rxvalid, 8'h00, rd);
        3: rx_frame(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0);
        4: bus(1, 1, 8'($urandom_range(0, 255)), rd);
        default: idle($urandom_range(1, 40));
      endcase
    end
    drain("rand_drain");
    bus(0, 1, 8'h00, rd);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
